pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline registers (IF2ID, ID2EX, EX2MEM, MEM2WB) and the PC register.
- Detects load-use hazards, taken branches/jumps and external interrupts.
- Stretches data-memory accesses that take more than one cycle.
- Drives per-stage write-enable/flush strobes and the exception PC-select; owns no datapath state.

Parameters:
- MEM_WAIT_MAX, 15: maximum consecutive dmem_wait cycles before mem_timeout asserts.
- CNT_W, 4: width of the memory-wait counter; must hold MEM_WAIT_MAX.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- ex_memread  in  1  instruction in EX is a load
- ex_regaddr  in  5  destination register of instruction in EX
- id_jump  in  1  J/JAL/JR/JALR decoded in ID
- ex_branch_taken  in  1  branch resolved taken in EX
- irq  in  1  level interrupt request
- id_kernel  in  1  PC[31] of ID instruction; 1 = kernel mode, interrupts masked
- dmem_wait  in  1  data memory not ready for MEM-stage access
- pc_write  out  1  PC register enable
- if2id_write  out  1  IF2ID enable
- if2id_flush  out  1  IF2ID loads bubble
- id2ex_flush  out  1  ID2EX loads bubble
- ex2mem_flush  out  1  EX2MEM loads bubble
- pipe_freeze  out  1  all stage registers and PC hold
- exc_take  out  1  PC-select forced to exception vector 0x8000_0004; ID2EX captures link PC
- mem_timeout  out  1  one-cycle pulse on memory timeout
- state_dbg  out  3  current FSM state encoding

Behaviour:
- Outputs are registered-state-derived combinational decodes of FSM state plus current inputs.
- Reset values (reset asserted or first cycle after it): state RUN, pc_write=1, if2id_write=1, all flush=0, pipe_freeze=0, exc_take=0, mem_timeout=0, wait counter 0.
- Reset is evaluated only at clk rising edge; reset mid-MEM_WAIT or mid-IRQ sequence abandons it, with no residual strobes.
- States: RUN=0, LU_STALL=1, MEM_WAIT=2, IRQ_PEND=3, IRQ_TAKE=4.
- Load-use hazard (lu) = ex_memread & ex_regaddr!=0 & ((id_use_rs & id_rs==ex_regaddr) | (id_use_rt & id_rt==ex_regaddr)).
- Priority, highest first: dmem_wait > ex_branch_taken > irq > id_jump > lu.
- RUN:
  - dmem_wait: pipe_freeze=1, pc_write=0, if2id_write=0; go MEM_WAIT, counter=1.
  - ex_branch_taken: if2id_flush=1 and id2ex_flush=1 same cycle; stay RUN.
  - irq & !id_kernel & !ex_branch_taken: go IRQ_PEND; pc_write=0, if2id_write=0.
  - id_jump: if2id_flush=1.
  - lu: pc_write=0, if2id_write=0, id2ex_flush=1; go LU_STALL.
- LU_STALL:
  - Exactly one bubble, then return to RUN; hazard no longer visible since the load has advanced.
  - A second lu in this cycle (cannot occur legally) is ignored.
  - dmem_wait here overrides: go MEM_WAIT.
- MEM_WAIT:
  - Freeze held while dmem_wait=1; counter increments.
  - dmem_wait deasserts: return to RUN next cycle, counter cleared.
  - Counter reaches MEM_WAIT_MAX: mem_timeout pulses once, return to RUN (access abandoned), counter cleared.
- IRQ_PEND:
  - One drain cycle; id2ex_flush=1, so the ID instruction is re-executed after return.
  - Next state is IRQ_TAKE.
  - ex_branch_taken in this cycle: flush per branch and return to RUN; irq re-sampled later.
- IRQ_TAKE:
  - exc_take=1, pc_write=1, if2id_flush=1, ex2mem_flush=0 (older instructions complete).
  - Next state is RUN.
  - irq still high in RUN is masked because the fetched PC is now kernel.
- Simultaneous lu and ex_branch_taken: branch wins, no stall.
- Simultaneous irq and dmem_wait: freeze first; irq re-evaluated on return to RUN.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined: adds outputs stall_cnt[31:0], flush_cnt[31:0], irq_cnt[31:0].
  - Counts cycles with pc_write=0, cycles with any flush, and IRQ_TAKE entries.
  - Counters saturate at 0xFFFF_FFFF and clear on reset.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg: state encodings, exception vector 0x8000_0004, reset PC 0x8000_0000, PCSrc select codes (3-bit, exception = 3'b100).
- One natural sub-module: hazard_lu_detect (combinational lu compare), reused by the forwarding unit.

Test Plan:
- Load-use: ex_memread=1, ex_regaddr=8, id_rs=8, id_use_rs=1 -> one cycle pc_write=0, id2ex_flush=1; next cycle RUN, pc_write=1.
- Load to $0: ex_regaddr=0 with matching id_rs=0 -> no stall.
- Branch + lu same cycle -> if2id_flush=1, id2ex_flush=1, pc_write=1, state stays RUN.
- dmem_wait held 3 cycles -> pipe_freeze=1 for 3 cycles, RUN on 4th, mem_timeout never; held 20 cycles with MEM_WAIT_MAX=15 -> mem_timeout pulse on cycle 15, then RUN.
- irq=1, id_kernel=0 -> IRQ_PEND, then IRQ_TAKE with exc_take=1, if2id_flush=1; with id_kernel=1 -> no response.
- Reset asserted during MEM_WAIT -> next cycle state_dbg=0, pipe_freeze=0, counter 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared encodings for the pipeline hazard sequencer and its neighbours
package pipe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int STATE_W    = 3;

  localparam logic [STATE_W-1:0] ST_RUN      = 3'd0;
  localparam logic [STATE_W-1:0] ST_LU_STALL = 3'd1;
  localparam logic [STATE_W-1:0] ST_MEM_WAIT = 3'd2;
  localparam logic [STATE_W-1:0] ST_IRQ_PEND = 3'd3;
  localparam logic [STATE_W-1:0] ST_IRQ_TAKE = 3'd4;

  localparam logic [31:0] EXC_VECTOR = 32'h8000_0004;
  localparam logic [31:0] RESET_PC   = 32'h8000_0000;

  typedef enum logic [2:0] {
    PCSRC_SEQ    = 3'b000,
    PCSRC_BRANCH = 3'b001,
    PCSRC_JUMP   = 3'b010,
    PCSRC_JREG   = 3'b011,
    PCSRC_EXC    = 3'b100
  } pcsrc_e;

  typedef struct packed {
    logic pc_write;
    logic if2id_write;
    logic if2id_flush;
    logic id2ex_flush;
    logic ex2mem_flush;
    logic pipe_freeze;
    logic exc_take;
  } strobe_t;

  localparam strobe_t STROBE_RUN    = 7'b1100000;
  localparam strobe_t STROBE_FREEZE = 7'b0000010;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard sequencer signal bundle; HAZ_PERF_CNT_EN adds counter outputs
interface pipe_hazard_ctrl_if
  import pipe_pkg::*;
;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_use_rs;
  logic                  id_use_rt;
  logic                  ex_memread;
  logic [REG_ADDR_W-1:0] ex_regaddr;
  logic                  id_jump;
  logic                  ex_branch_taken;
  logic                  irq;
  logic                  id_kernel;
  logic                  dmem_wait;

  logic                  pc_write;
  logic                  if2id_write;
  logic                  if2id_flush;
  logic                  id2ex_flush;
  logic                  ex2mem_flush;
  logic                  pipe_freeze;
  logic                  exc_take;
  logic                  mem_timeout;
  logic [STATE_W-1:0]    state_dbg;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0]           stall_cnt;
  logic [31:0]           flush_cnt;
  logic [31:0]           irq_cnt;
`endif

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, ex_memread, ex_regaddr,
           id_jump, ex_branch_taken, irq, id_kernel, dmem_wait,
`ifdef HAZ_PERF_CNT_EN
    input  stall_cnt, flush_cnt, irq_cnt,
`endif
    input  pc_write, if2id_write, if2id_flush, id2ex_flush, ex2mem_flush,
           pipe_freeze, exc_take, mem_timeout, state_dbg
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, ex_memread, ex_regaddr,
           id_jump, ex_branch_taken, irq, id_kernel, dmem_wait,
`ifdef HAZ_PERF_CNT_EN
    output stall_cnt, flush_cnt, irq_cnt,
`endif
    output pc_write, if2id_write, if2id_flush, id2ex_flush, ex2mem_flush,
           pipe_freeze, exc_take, mem_timeout, state_dbg
  );

endinterface

// File: rtl/hazard_lu_detect.sv
// rtl/hazard_lu_detect.sv - load-use compare between the load in EX and the sources of ID
module hazard_lu_detect
  import pipe_pkg::*;
(
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_regaddr,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  output logic                  lu
);

  logic rs_hit;
  logic rt_hit;

  always_comb begin
    rs_hit = id_use_rs && (id_rs == ex_regaddr);
    rt_hit = id_use_rt && (id_rt == ex_regaddr);
    // $0 is hardwired, so a load targeting it never creates a dependency
    lu     = ex_memread && (ex_regaddr != '0) && (rs_hit || rt_hit);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush/exception sequencer
// HAZ_PERF_CNT_EN enables saturating stall/flush/irq counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  pipe_hazard_ctrl_if.slave        hz
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               lu;
  logic               timeout;
  strobe_t            st;

  hazard_lu_detect u_lu (
    .ex_memread (hz.ex_memread),
    .ex_regaddr (hz.ex_regaddr),
    .id_rs      (hz.id_rs),
    .id_rt      (hz.id_rt),
    .id_use_rs  (hz.id_use_rs),
    .id_use_rt  (hz.id_use_rt),
    .lu         (lu)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    st      = STROBE_RUN;
    timeout = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (hz.dmem_wait) begin
          st      = STROBE_FREEZE;
          state_d = ST_MEM_WAIT;
          cnt_d   = CNT_W'(1);
        end else if (hz.ex_branch_taken) begin
          st.if2id_flush = 1'b1;
          st.id2ex_flush = 1'b1;
        end else if (hz.irq && !hz.id_kernel) begin
          st.pc_write    = 1'b0;
          st.if2id_write = 1'b0;
          state_d        = ST_IRQ_PEND;
        end else if (hz.id_jump) begin
          st.if2id_flush = 1'b1;
        end else if (lu) begin
          st.pc_write    = 1'b0;
          st.if2id_write = 1'b0;
          st.id2ex_flush = 1'b1;
          state_d        = ST_LU_STALL;
        end
      end
      ST_LU_STALL: begin
        // the bubble now sits in EX, so any lu seen here is not real
        if (hz.dmem_wait) begin
          st      = STROBE_FREEZE;
          state_d = ST_MEM_WAIT;
          cnt_d   = CNT_W'(1);
        end else begin
          state_d = ST_RUN;
          if (hz.ex_branch_taken) begin
            st.if2id_flush = 1'b1;
            st.id2ex_flush = 1'b1;
          end else if (hz.id_jump) begin
            st.if2id_flush = 1'b1;
          end
        end
      end
      ST_MEM_WAIT: begin
        if (hz.dmem_wait) begin
          st = STROBE_FREEZE;
          if (cnt_q == CNT_W'(MEM_WAIT_MAX - 1)) begin
            timeout = 1'b1;
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_IRQ_PEND: begin
        if (hz.dmem_wait) begin
          st      = STROBE_FREEZE;
          state_d = ST_MEM_WAIT;
          cnt_d   = CNT_W'(1);
        end else if (hz.ex_branch_taken) begin
          st.if2id_flush = 1'b1;
          st.id2ex_flush = 1'b1;
          state_d        = ST_RUN;
        end else begin
          st.pc_write    = 1'b0;
          st.if2id_write = 1'b0;
          st.id2ex_flush = 1'b1;
          state_d        = ST_IRQ_TAKE;
        end
      end
      ST_IRQ_TAKE: begin
        if (hz.dmem_wait) begin
          st      = STROBE_FREEZE;
          state_d = ST_MEM_WAIT;
          cnt_d   = CNT_W'(1);
        end else begin
          st.exc_take    = 1'b1;
          st.if2id_flush = 1'b1;
          state_d        = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hz.pc_write     = st.pc_write;
  assign hz.if2id_write  = st.if2id_write;
  assign hz.if2id_flush  = st.if2id_flush;
  assign hz.id2ex_flush  = st.id2ex_flush;
  assign hz.ex2mem_flush = st.ex2mem_flush;
  assign hz.pipe_freeze  = st.pipe_freeze;
  assign hz.exc_take     = st.exc_take;
  assign hz.mem_timeout  = timeout;
  assign hz.state_dbg    = state_q;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic [31:0] irq_cnt_q,   irq_cnt_d;

  always_comb begin
    stall_cnt_d = st.pc_write ? stall_cnt_q : sat_inc32(stall_cnt_q);
    flush_cnt_d = (st.if2id_flush || st.id2ex_flush || st.ex2mem_flush)
                  ? sat_inc32(flush_cnt_q) : flush_cnt_q;
    irq_cnt_d   = (state_d == ST_IRQ_TAKE && state_q != ST_IRQ_TAKE)
                  ? sat_inc32(irq_cnt_q) : irq_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      irq_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      irq_cnt_q   <= irq_cnt_d;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
  assign hz.irq_cnt   = irq_cnt_q;
`endif

endmodule
